bz_deserializer: RTL and testbench

- Receive-side counterpart of the Core-to-router serializer.
- Pops 11-bit router flits from a show-ahead FIFO fed by the router and reassembles each 3-flit data group into one {code | payload} word.
- Presents each word to the Core on a Channel with the packet's route field.
- One header flit may be followed by any number of 3-flit data groups; the flit with tail=1 ends the packet.

---
 rtl/bz_deserializer.sv | 105 ++++++++++
 tb/tb_bz_deserializer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bz_deserializer.sv
// Router-to-Core deserializer: folds 11-bit flits (header + 3-flit data groups) into {code|payload} words.
// Optional malformed-packet counter enabled by BZ_DESERIALIZER_ERRCNT_EN. Channel flattened to PC_out_channel_{d,v,a}.
module bz_deserializer #(
  parameter int unsigned NPCcode   = 7,
  parameter int unsigned NPCdata   = 20,
  parameter int unsigned NROUTE    = 10,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [10:0]                fifo_q,
  input  logic                       fifo_empty,
  output logic                       fifo_rdreq,
  output logic [NPCcode+NPCdata-1:0] PC_out_channel_d,
  output logic                       PC_out_channel_v,
  input  logic                       PC_out_channel_a,
  output logic [NROUTE-1:0]          route_out
`ifdef BZ_DESERIALIZER_ERRCNT_EN
  ,
  output logic [ERR_CNT_W-1:0]       err_count
`endif
);

  typedef enum logic [2:0] {
    HDR,
    D1,
    D2,
    D3,
    OUT
  } state_t;

  state_t               state_q;
  logic [NROUTE-1:0]    route_q;
  logic [NPCcode-1:0]   code_q;
  logic [NPCdata-1:0]   pay_q;
  logic                 last_q;
  logic                 v_q;
  logic                 tail;
  logic [9:0]           flit_data;

  assign tail      = fifo_q[10];
  assign flit_data = fifo_q[9:0];

  // Reset gates the pop so no flit is lost while the FSM is held in reset.
  assign fifo_rdreq = reset_n & ~fifo_empty & (state_q != OUT);

  assign PC_out_channel_d = {code_q, pay_q};
  assign PC_out_channel_v = v_q;
  assign route_out        = route_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HDR;
      route_q <= '0;
      code_q  <= '0;
      pay_q   <= '0;
      last_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      unique case (state_q)
        HDR: if (fifo_rdreq) begin
          route_q <= NROUTE'(flit_data);
          if (!tail) state_q <= D1;
        end
        D1: if (fifo_rdreq) begin
          code_q  <= fifo_q[NPCcode-1:0];
          state_q <= tail ? HDR : D2;
        end
        D2: if (fifo_rdreq) begin
          pay_q[NPCdata-1 -: 10] <= flit_data;
          state_q <= tail ? HDR : D3;
        end
        D3: if (fifo_rdreq) begin
          pay_q[9:0] <= flit_data;
          last_q     <= tail;
          v_q        <= 1'b1;
          state_q    <= OUT;
        end
        OUT: if (PC_out_channel_a) begin
          v_q     <= 1'b0;
          state_q <= last_q ? HDR : D1;
        end
        default: state_q <= HDR;
      endcase
    end
  end

`ifdef BZ_DESERIALIZER_ERRCNT_EN
  logic                 malformed;
  logic [ERR_CNT_W-1:0] err_q;

  assign malformed = fifo_rdreq & tail & ((state_q == HDR) | (state_q == D1) | (state_q == D2));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= '0;
    end else if (malformed && (err_q != '1)) begin
      err_q <= err_q + ERR_CNT_W'(1);
    end
  end

  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_bz_deserializer.sv
// Scoreboard bench for bz_deserializer: a show-ahead FIFO model feeds flits, expected words are queued
// as packets are pushed and compared when the DUT presents a valid word.
module tb_bz_deserializer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] fifo_q;
  logic        fifo_empty;
  logic        fifo_rdreq;
  logic [26:0] ch_d;
  logic        ch_v;
  logic        ch_a;
  logic [9:0]  route_out;
`ifdef BZ_DESERIALIZER_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  always #5 clk = ~clk;

  bz_deserializer #(.NPCcode(7), .NPCdata(20), .NROUTE(10), .ERR_CNT_W(8)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .fifo_q           (fifo_q),
    .fifo_empty       (fifo_empty),
    .fifo_rdreq       (fifo_rdreq),
    .PC_out_channel_d (ch_d),
    .PC_out_channel_v (ch_v),
    .PC_out_channel_a (ch_a),
    .route_out        (route_out)
`ifdef BZ_DESERIALIZER_ERRCNT_EN
    ,
    .err_count        (err_count)
`endif
  );

  logic [10:0] fq[$];
  logic [26:0] exp_d[$];
  logic [9:0]  exp_r[$];
  int          hold;
  bit          bubbles;
  int          pops;
  int          n_checks;
  int          n_fail;

  task automatic refresh();
    fifo_q     = (fq.size() != 0) ? fq[0] : 11'h000;
    fifo_empty = (fq.size() == 0) || (hold != 0);
  endtask

  task automatic push(input logic [10:0] f);
    fq.push_back(f);
    refresh();
  endtask

  task automatic expect_word(input logic [26:0] d, input logic [9:0] r);
    exp_d.push_back(d);
    exp_r.push_back(r);
  endtask

  // Advance one clock: model the FIFO pop on the edge, then return at the following negedge.
  task automatic step();
    @(posedge clk);
    if (fifo_rdreq) begin
      void'(fq.pop_front());
      pops++;
      if (bubbles) hold = 3;
    end else if (hold > 0) begin
      hold--;
    end
    #1 refresh();
    @(negedge clk);
  endtask

  // Wait (bounded) for a valid word, capture it and acknowledge it.
  task automatic collect(input int budget, output logic [26:0] gd, output logic [9:0] gr,
                         output int waited, output bit ok);
    ok = 1'b0; waited = 0; gd = '0; gr = '0;
    for (int i = 0; i < budget; i++) begin
      if (ch_v) begin
        gd = ch_d; gr = route_out;
        ch_a = 1'b1;
        step();
        ch_a = 1'b0;
        ok = 1'b1;
        break;
      end
      step();
      waited++;
    end
  endtask

  task automatic push_pkt1();
    push(11'h005); push(11'h07F); push(11'h3FF); push(11'h555);
    expect_word(27'h7FFFD55, 10'h005);
  endtask

  logic [26:0] gd, ed;
  logic [9:0]  gr, er;
  int          waited;
  bit          ok;

  task automatic test_reset();
    reset_n = 1'b0; ch_a = 1'b0; hold = 0; bubbles = 0; pops = 0;
    refresh();
    #2;
    n_checks++;
    if (ch_v !== 1'b0 || fifo_rdreq !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: v=%b rdreq=%b, want 0 0", ch_v, fifo_rdreq);
    end
    n_checks++;
    if (ch_d !== 27'h0 || route_out !== 10'h0) begin
      n_fail++; $display("FAIL reset_data: d=%h route=%h, want 0 0", ch_d, route_out);
    end
`ifdef BZ_DESERIALIZER_ERRCNT_EN
    n_checks++;
    if (err_count !== 8'h00) begin
      n_fail++; $display("FAIL reset_err: err=%0d, want 0", err_count);
    end
`endif
    @(negedge clk); step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    push_pkt1();
    collect(30, gd, gr, waited, ok);
    ed = exp_d.pop_front(); er = exp_r.pop_front();
    n_checks++;
    if (!ok || gd !== ed || gr !== er) begin
      n_fail++; $display("FAIL single_word: ok=%b d=%h route=%h, want d=%h route=%h", ok, gd, gr, ed, er);
    end
  endtask

  task automatic test_two_word();
    int p0;
    p0 = pops;
    push(11'h003); push(11'h012); push(11'h000); push(11'h001);
    push(11'h013); push(11'h3FF); push(11'h400);
    expect_word(27'h1200001, 10'h003);
    expect_word(27'h13FFC00, 10'h003);
    collect(30, gd, gr, waited, ok);
    ed = exp_d.pop_front(); er = exp_r.pop_front();
    n_checks++;
    if (!ok || gd !== ed || gr !== er) begin
      n_fail++; $display("FAIL two_word_0: ok=%b d=%h route=%h, want d=%h route=%h", ok, gd, gr, ed, er);
    end
    collect(30, gd, gr, waited, ok);
    ed = exp_d.pop_front(); er = exp_r.pop_front();
    n_checks++;
    if (!ok || gd !== ed || gr !== er) begin
      n_fail++; $display("FAIL two_word_1: ok=%b d=%h route=%h, want d=%h route=%h", ok, gd, gr, ed, er);
    end
    n_checks++;
    if (waited !== 3) begin
      n_fail++; $display("FAIL two_word_gap: cycles=%0d, want 3 (no header revisit)", waited);
    end
    step(); step();
    n_checks++;
    if (pops - p0 !== 7) begin
      n_fail++; $display("FAIL two_word_pops: pops=%0d, want 7", pops - p0);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    push_pkt1();
    push(11'h009); push(11'h001); push(11'h002); push(11'h403);
    expect_word(27'h0100803, 10'h009);
    for (int i = 0; i < 30 && !ch_v; i++) step();
    ed = exp_d.pop_front(); er = exp_r.pop_front();
    n_checks++;
    if (ch_v !== 1'b1) begin
      n_fail++; $display("FAIL bp_valid: v=%b, want 1", ch_v);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (ch_v !== 1'b1 || ch_d !== ed || route_out !== er || fifo_rdreq !== 1'b0) begin
        n_fail++; bad++;
        $display("FAIL bp_hold[%0d]: v=%b d=%h route=%h rdreq=%b, want 1 %h %h 0",
                 i, ch_v, ch_d, route_out, fifo_rdreq, ed, er);
      end
      step();
    end
    ch_a = 1'b1; step(); ch_a = 1'b0;
    n_checks++;
    if (ch_v !== 1'b0 || fq.size() != 4) begin
      n_fail++; $display("FAIL bp_release: v=%b queued=%0d, want 0 4", ch_v, fq.size());
    end
    collect(30, gd, gr, waited, ok);
    ed = exp_d.pop_front(); er = exp_r.pop_front();
    n_checks++;
    if (!ok || gd !== ed || gr !== er) begin
      n_fail++; $display("FAIL bp_next: ok=%b d=%h route=%h, want d=%h route=%h", ok, gd, gr, ed, er);
    end
  endtask

  task automatic test_bubbles();
    int bad, p0;
    bubbles = 1'b1; p0 = pops;
    push_pkt1();
    bad = 0;
    for (int i = 0; i < 80 && !ch_v; i++) begin
      if (fifo_rdreq && fifo_empty) bad++;
      step();
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL bubble_rdreq: rdreq while empty %0d times, want 0", bad);
    end
    collect(5, gd, gr, waited, ok);
    ed = exp_d.pop_front(); er = exp_r.pop_front();
    n_checks++;
    if (!ok || gd !== ed || gr !== er || pops - p0 !== 4) begin
      n_fail++; $display("FAIL bubble_word: ok=%b d=%h route=%h pops=%0d, want d=%h route=%h pops=4",
                         ok, gd, gr, pops - p0, ed, er);
    end
    for (int i = 0; i < 4; i++) step();
    bubbles = 1'b0;
  endtask

  task automatic test_malformed();
    push(11'h004); push(11'h405);
    push_pkt1();
    collect(30, gd, gr, waited, ok);
    ed = exp_d.pop_front(); er = exp_r.pop_front();
    n_checks++;
    if (!ok || gd !== ed || gr !== er) begin
      n_fail++; $display("FAIL malformed_then_good: ok=%b d=%h route=%h, want d=%h route=%h", ok, gd, gr, ed, er);
    end
`ifdef BZ_DESERIALIZER_ERRCNT_EN
    n_checks++;
    if (err_count !== 8'd1) begin
      n_fail++; $display("FAIL malformed_err: err=%0d, want 1", err_count);
    end
`endif
    // Header-only packet, then route 0x200 passed through untouched.
    push(11'h600);
    push(11'h200); push(11'h07F); push(11'h3FF); push(11'h555);
    expect_word(27'h7FFFD55, 10'h200);
    collect(30, gd, gr, waited, ok);
    ed = exp_d.pop_front(); er = exp_r.pop_front();
    n_checks++;
    if (!ok || gd !== ed || gr !== er) begin
      n_fail++; $display("FAIL route31_pass: ok=%b d=%h route=%h, want d=%h route=%h", ok, gd, gr, ed, er);
    end
`ifdef BZ_DESERIALIZER_ERRCNT_EN
    n_checks++;
    if (err_count !== 8'd2) begin
      n_fail++; $display("FAIL hdr_only_err: err=%0d, want 2", err_count);
    end
    for (int i = 0; i < 260; i++) push(11'h400);
    for (int i = 0; i < 300 && fq.size() != 0; i++) step();
    n_checks++;
    if (err_count !== 8'hFF || ch_v !== 1'b0) begin
      n_fail++; $display("FAIL err_saturate: err=%0d v=%b, want 255 0", err_count, ch_v);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int p0;
    p0 = pops;
    push(11'h00A); push(11'h011); push(11'h022);
    for (int i = 0; i < 20 && (pops - p0) < 3; i++) step();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (ch_v !== 1'b0 || ch_d !== 27'h0 || route_out !== 10'h0) begin
      n_fail++; $display("FAIL mid_reset_out: v=%b d=%h route=%h, want 0 0 0", ch_v, ch_d, route_out);
    end
`ifdef BZ_DESERIALIZER_ERRCNT_EN
    n_checks++;
    if (err_count !== 8'h00) begin
      n_fail++; $display("FAIL mid_reset_err: err=%0d, want 0", err_count);
    end
`endif
    push(11'h006); push(11'h001); push(11'h002); push(11'h403);
    expect_word(27'h0100803, 10'h006);
    p0 = pops;
    @(negedge clk); step();
    n_checks++;
    if (fifo_rdreq !== 1'b0 || pops !== p0) begin
      n_fail++; $display("FAIL mid_reset_rdreq: rdreq=%b pops=%0d, want 0 0", fifo_rdreq, pops - p0);
    end
    reset_n = 1'b1;
    collect(30, gd, gr, waited, ok);
    ed = exp_d.pop_front(); er = exp_r.pop_front();
    n_checks++;
    if (!ok || gd !== ed || gr !== er) begin
      n_fail++; $display("FAIL after_reset_word: ok=%b d=%h route=%h, want d=%h route=%h", ok, gd, gr, ed, er);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    test_reset();
    test_single();
    test_two_word();
    test_backpressure();
    test_bubbles();
    test_malformed();
    test_reset_mid();
    n_checks++;
    if (exp_d.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d words never seen, want 0", exp_d.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
